key_search_ctrl: RTL and testbench
==================================

# key_search_ctrl

Round-robin search controller that shares one AES encryption engine among `LANES` key-generator lanes in the brute-force key search. Each cycle of the search it picks the next non-exhausted lane, hands that lane's candidate key to the engine, and compares the returned ciphertext with the target. On mismatch it advances that lane; on match it latches the key and lane. It sits between the keygen array and the AES core and is the only block that drives keygen advance strobes.

## Interface
- `LANES`, 4: number of keygen lanes, 1..16.
- `LW`, 2: lane index width, equal to clog2(`LANES`), minimum 1.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: pulse that begins or resumes a search.
- `abort` in 1: pulse that stops the search and returns to IDLE.
- `target` in [0:127]: expected ciphertext.
- `kg_key` in [LANES*128-1:0]: lane i candidate key at `[i*128 +: 128]`.
- `kg_done` in [LANES-1:0]: lane i key space exhausted; its key is invalid.
- `kg_ena` out [LANES-1:0]: one-hot advance strobe to lane i.
- `aes_key` out [0:127]: key presented to the engine.
- `aes_start` out 1: request to the engine. A transfer occurs when `aes_start` and `aes_ready` are both high.
- `aes_ready` in 1: engine can accept a request.
- `aes_valid` in 1: one-cycle result strobe.
- `aes_out` in [0:127]: engine ciphertext.
- `busy` out 1: state is not IDLE, FOUND or EXHAUSTED.
- `found` out 1: match latched.
- `found_key` out [0:127]: key that produced the match.
- `found_lane` out [LW-1:0]: lane that produced the match.
- `exhausted` out 1: all lanes done with no match.
- `tried_cnt` out [31:0]: number of candidates checked since start; saturates at 2^32-1.

## Operation
- States: IDLE, SELECT, ISSUE, WAIT, CHECK, FOUND, EXHAUSTED.
- IDLE, on `start`:
  - clear `found`, `exhausted` and `tried_cnt`;
  - set ptr to 0;
  - go to SELECT.
- SELECT (1 cycle):
  - Search lanes ptr, ptr+1, … (mod `LANES`) for the first lane with `kg_done`=0.
  - None found: go to EXHAUSTED.
  - Otherwise latch cur_lane and `aes_key` = that lane's `kg_key`, then go to ISSUE.
- ISSUE: hold `aes_start`=1 until `aes_ready`=1, then go to WAIT. Exactly one transfer per candidate.
- WAIT: on `aes_valid`, register `aes_out` as result and go to CHECK.
- CHECK (1 cycle):
  - Increment `tried_cnt`, saturating.
  - result == `target`: set `found`=1, `found_key`=`aes_key`, `found_lane`=cur_lane; go to FOUND.
  - Otherwise:
    - drive `kg_ena[cur_lane]`=1 combinationally during this cycle, so the lane updates at the closing edge;
    - set ptr = cur_lane+1 mod `LANES`;
    - go to SELECT.
- FOUND and EXHAUSTED are terminal and hold their flags.
- `start` in FOUND:
  - clear `found` and `tried_cnt`;
  - pulse `kg_ena[found_lane]` in that cycle, so the search resumes past the match;
  - set ptr = `found_lane`+1;
  - go to SELECT.
- `start` in EXHAUSTED: behaves as `start` in IDLE.
- `abort` in any state: next state is IDLE.
  - `found` and `exhausted` are cleared.
  - No `kg_ena` or `aes_start` is driven in the abort cycle.
  - A late `aes_valid` is ignored.
- Simultaneous `start` and `abort`: `abort` wins.
- `start` while busy: ignored.
- `aes_valid` outside WAIT: ignored.
- `kg_ena` is never asserted outside CHECK or the FOUND-restart cycle. At most one bit is high.

## Timing
- Reset (synchronous): state IDLE, ptr 0.
  - `kg_ena`, `aes_start`, `busy`, `found`, `exhausted`, `tried_cnt`, `found_lane`: 0.
  - `aes_key`, `found_key`: 0.
- Reset mid-transaction drops the pending engine result with no `kg_ena` pulse.
- `start` at cycle t: SELECT at t+1, ISSUE at t+2.
- With `aes_ready`=1 and `aes_valid` one cycle after the transfer, one candidate costs 4 cycles: SELECT, ISSUE, WAIT, CHECK.
- Engine latency L: per-candidate cost is 3+L cycles, plus any `aes_ready` stall.
- `found` and `exhausted` assert the cycle after CHECK or SELECT respectively; `busy` deasserts in the same cycle.
- `LANES`=1: ptr is always 0.

## Test plan
- Match found: `LANES`=2, engine latency 3, target equals the encryption of lane 1's third key.
  - Lanes are serviced in the order 0,1,0,1,0,1.
  - Required: `found`=1, `found_lane`=1, `tried_cnt`=6, and `kg_ena` pulses exactly 5 times.
- All lanes done at start: `kg_done`=all ones, then `start`.
  - Required: `exhausted`=1 at t+2 and `aes_start` never high.
- Skipping a done lane: `kg_done[0]`=1 and lane 1 active for 3 mismatches, then lane 1 done.
  - Required: only `kg_ena[1]` pulses, 3 times; then `exhausted`=1 with `tried_cnt`=3.
- Engine back-pressure: `aes_ready` low for 5 cycles in ISSUE.
  - Required: `aes_start` held for 6 cycles with `aes_key` stable, then exactly one WAIT.
- Abort and reset mid-transaction:
  - `abort` in WAIT, then `aes_valid` 2 cycles later. Required: IDLE, `busy`=0, `found`=0, no `kg_ena`.
  - `rst` in WAIT gives the same result.
- Restart after a match: from FOUND on lane 1, assert `start`.
  - Required: `kg_ena`=2'b10 in the start cycle, `tried_cnt`=0, and the next SELECT picks lane 0.

Source files
------------

// File: rtl/key_search_ctrl.sv
// Round-robin arbiter sharing one AES engine among keygen lanes.
// Compares each ciphertext with the target and advances lanes on miss.
module key_search_ctrl #(
  parameter int LANES = 4,
  parameter int LW    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [0:127]         target,
  input  logic [LANES*128-1:0] kg_key,
  input  logic [LANES-1:0]     kg_done,
  output logic [LANES-1:0]     kg_ena,
  output logic [0:127]         aes_key,
  output logic                 aes_start,
  input  logic                 aes_ready,
  input  logic                 aes_valid,
  input  logic [0:127]         aes_out,
  output logic                 busy,
  output logic                 found,
  output logic [0:127]         found_key,
  output logic [LW-1:0]        found_lane,
  output logic                 exhausted,
  output logic [31:0]          tried_cnt
);

  typedef enum logic [2:0] {
    IDLE, SELECT, ISSUE, WAIT, CHECK, FOUND, EXHAUSTED
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [LW-1:0]   ptr;
  logic [LW-1:0]   cur_lane;
  logic [LW-1:0]   sel_lane;
  logic            sel_ok;
  logic [127:0]    sel_key;
  logic [LANES-1:0] rot;
  logic [0:127]    result;
  logic            match;

  function automatic logic [LW-1:0] nxt(
    input logic [LW-1:0] l
  );
    if (int'(l) >= LANES - 1) return '0;
    return l + 1'b1;
  endfunction

  function automatic logic [LANES-1:0] oh(
    input logic [LW-1:0] l
  );
    logic [LANES-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++)
      if (LW'(i) == l) v[i] = 1'b1;
    return v;
  endfunction

  assign match = (result == target);

  // Rotate so bit k is lane ptr+k; the lowest clear bit wins.
  assign rot = LANES'({kg_done, kg_done} >> ptr);

  always_comb begin
    sel_ok   = 1'b0;
    sel_lane = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (!rot[k]) begin
        sel_ok   = 1'b1;
        sel_lane = (int'(ptr) + k >= LANES) ?
                   LW'(int'(ptr) + k - LANES) :
                   LW'(int'(ptr) + k);
      end
    end
  end

  always_comb begin
    sel_key = '0;
    for (int i = 0; i < LANES; i++)
      if (LW'(i) == sel_lane) sel_key = kg_key[i*128 +: 128];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE, FOUND, EXHAUSTED:
          if (start) state_nx = SELECT;
        SELECT:
          state_nx = sel_ok ? ISSUE : EXHAUSTED;
        ISSUE:
          if (aes_ready) state_nx = WAIT;
        WAIT:
          if (aes_valid) state_nx = CHECK;
        CHECK:
          state_nx = match ? FOUND : SELECT;
        default:
          state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    kg_ena    = '0;
    aes_start = 1'b0;
    busy      = (state == SELECT) || (state == ISSUE) ||
                (state == WAIT)   || (state == CHECK);
    if (!abort) begin
      unique case (1'b1)
        state == ISSUE:
          aes_start = 1'b1;
        state == CHECK && !match:
          kg_ena = oh(cur_lane);
        state == FOUND && start:
          kg_ena = oh(found_lane);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      cur_lane   <= '0;
      aes_key    <= '0;
      result     <= '0;
      found      <= 1'b0;
      found_key  <= '0;
      found_lane <= '0;
      exhausted  <= 1'b0;
      tried_cnt  <= '0;
    end else if (abort) begin
      found     <= 1'b0;
      exhausted <= 1'b0;
    end else begin
      unique case (state)
        IDLE, EXHAUSTED:
          if (start) begin
            found     <= 1'b0;
            exhausted <= 1'b0;
            tried_cnt <= '0;
            ptr       <= '0;
          end
        FOUND:
          if (start) begin
            found     <= 1'b0;
            tried_cnt <= '0;
            ptr       <= nxt(found_lane);
          end
        SELECT:
          if (sel_ok) begin
            cur_lane <= sel_lane;
            aes_key  <= sel_key;
          end else begin
            exhausted <= 1'b1;
          end
        WAIT:
          if (aes_valid) result <= aes_out;
        CHECK: begin
          if (tried_cnt != '1) tried_cnt <= tried_cnt + 1'b1;
          if (match) begin
            found      <= 1'b1;
            found_key  <= aes_key;
            found_lane <= cur_lane;
          end else begin
            ptr <= nxt(cur_lane);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_key_search_ctrl.sv
// Bench for key_search_ctrl: keygen and AES engine models,
// table of search scenarios plus multi-cycle corner sequences.
module tb_key_search_ctrl;

  localparam int LANES = 2;
  localparam int LW    = 1;

  logic                 clk = 1'b0;
  logic                 rst, start, abort, aes_ready;
  logic                 aes_valid = 1'b0;
  logic [127:0]         target;
  logic [127:0]         aes_out = '0;
  logic [127:0]         aes_key, found_key;
  logic [LANES*128-1:0] kg_key;
  logic [LANES-1:0]     kg_done, kg_ena;
  logic                 aes_start, busy, found, exhausted;
  logic [LW-1:0]        found_lane;
  logic [31:0]          tried_cnt;

  int nvec = 0;
  int nerr = 0;
  int cnt[LANES];
  int lim[LANES];
  int ena_cnt[LANES];
  int ast_cnt, xfer_cnt, bad_oh, lat, pend;
  logic kg_clr, mon_clr;

  key_search_ctrl #(.LANES(LANES), .LW(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .target(target), .kg_key(kg_key), .kg_done(kg_done),
    .kg_ena(kg_ena), .aes_key(aes_key), .aes_start(aes_start),
    .aes_ready(aes_ready), .aes_valid(aes_valid),
    .aes_out(aes_out), .busy(busy), .found(found),
    .found_key(found_key), .found_lane(found_lane),
    .exhausted(exhausted), .tried_cnt(tried_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] kf(int l, int c);
    return {32'hDEADBEEF, 32'(l), 32'h0BADF00D, 32'(c)};
  endfunction

  function automatic logic [127:0] enc(logic [127:0] k);
    return k ^ {4{32'h5A5A5A5A}};
  endfunction

  always_comb begin
    kg_key  = '0;
    kg_done = '0;
    for (int i = 0; i < LANES; i++) begin
      kg_key[i*128 +: 128] = kf(i, cnt[i]);
      kg_done[i] = (cnt[i] >= lim[i]);
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (kg_clr) cnt[i] <= 0;
      else if (kg_ena[i]) cnt[i] <= cnt[i] + 1;
    end
  end

  // Engine: valid arrives lat cycles after the transfer edge.
  always @(posedge clk) begin
    if (aes_start && aes_ready) begin
      pend      <= lat - 1;
      aes_valid <= (lat == 1);
      aes_out   <= enc(aes_key);
    end else if (pend > 0) begin
      pend      <= pend - 1;
      aes_valid <= (pend == 1);
    end else begin
      aes_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if ((kg_ena & (kg_ena - 1'b1)) != '0) bad_oh <= bad_oh + 1;
    if (mon_clr) begin
      for (int i = 0; i < LANES; i++) ena_cnt[i] <= 0;
      ast_cnt  <= 0;
      xfer_cnt <= 0;
    end else begin
      for (int i = 0; i < LANES; i++)
        if (kg_ena[i]) ena_cnt[i] <= ena_cnt[i] + 1;
      if (aes_start) ast_cnt <= ast_cnt + 1;
      if (aes_start && aes_ready) xfer_cnt <= xfer_cnt + 1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic prep(input int l0, input int l1,
                      input int lt, input logic [127:0] tg);
    lim[0]    = l0;
    lim[1]    = l1;
    lat       = lt;
    target    = tg;
    aes_ready = 1'b1;
    start     = 1'b0;
    abort     = 1'b1;
    kg_clr    = 1'b1;
    mon_clr   = 1'b1;
    cyc();
    abort   = 1'b0;
    kg_clr  = 1'b0;
    mon_clr = 1'b0;
    cyc();
  endtask

  typedef struct {
    int   lim0, lim1, lat, tl, tc;
    logic exp_found, exp_exh;
    int   exp_lane, exp_tried, exp_e0, exp_e1, exp_cyc;
  } vec_t;

  vec_t vt[6];

  task automatic run_vec(input vec_t v);
    int n;
    logic [127:0] tg;
    tg = (v.tl < 0) ? '1 : enc(kf(v.tl, v.tc));
    prep(v.lim0, v.lim1, v.lat, tg);
    start = 1'b1;
    cyc();
    start = 1'b0;
    n = 1;
    while (busy && n < 400) begin
      cyc();
      n++;
    end
    chk("cycles", n, v.exp_cyc);
    chk("found", found, v.exp_found);
    chk("exhausted", exhausted, v.exp_exh);
    chk("tried_cnt", tried_cnt, v.exp_tried);
    chk("ena0", ena_cnt[0], v.exp_e0);
    chk("ena1", ena_cnt[1], v.exp_e1);
    chk("aes_start_cycles", ast_cnt, v.exp_tried);
    if (v.exp_found) begin
      chk("found_lane", found_lane, v.exp_lane);
      chk("found_key", found_key, kf(v.tl, v.tc));
    end
  endtask

  initial begin
    logic [127:0] k0;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    aes_ready = 1'b1; lat = 1; target = '0;
    kg_clr = 1'b1; mon_clr = 1'b1; bad_oh = 0; pend = 0;
    lim[0] = 0; lim[1] = 0;
    // lim0 lim1 lat tl tc found exh lane tried e0 e1 cycles
    vt[0] = '{10, 10, 3,  1, 2, 1'b1, 1'b0, 1, 6, 3, 2, 37};
    vt[1] = '{ 0,  0, 1, -1, 0, 1'b0, 1'b1, 0, 0, 0, 0,  2};
    vt[2] = '{ 0,  3, 1, -1, 0, 1'b0, 1'b1, 0, 3, 0, 3, 14};
    vt[3] = '{ 2,  1, 1, -1, 0, 1'b0, 1'b1, 0, 3, 2, 1, 14};
    vt[4] = '{ 5,  5, 2,  0, 0, 1'b1, 1'b0, 0, 1, 0, 0,  6};
    vt[5] = '{ 0,  5, 4,  1, 0, 1'b1, 1'b0, 1, 1, 0, 0,  8};
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_kg_ena", kg_ena, 0);
    chk("rst_aes_start", aes_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_found", found, 0);
    chk("rst_exhausted", exhausted, 0);
    chk("rst_tried", tried_cnt, 0);
    chk("rst_found_lane", found_lane, 0);
    chk("rst_aes_key", aes_key, 0);
    chk("rst_found_key", found_key, 0);
    rst = 1'b0;
    kg_clr = 1'b0;
    mon_clr = 1'b0;
    cyc();

    for (int i = 0; i < 6; i++) run_vec(vt[i]);

    // Restart from a match on lane 1.
    run_vec(vt[0]);
    start = 1'b1;
    @(negedge clk);
    chk("restart_kg_ena", kg_ena, 2'b10);
    cyc();
    start = 1'b0;
    @(negedge clk);
    chk("restart_tried", tried_cnt, 0);
    chk("restart_found", found, 0);
    cyc();
    @(negedge clk);
    chk("restart_aes_start", aes_start, 1);
    chk("restart_lane0_key", aes_key, kf(0, 3));

    // Engine back-pressure: ready low for 5 ISSUE cycles.
    prep(10, 10, 1, '1);
    aes_ready = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    @(negedge clk);
    k0 = aes_key;
    chk("bp_key0", k0, kf(0, 0));
    for (int i = 0; i < 4; i++) begin
      cyc();
      @(negedge clk);
      chk("bp_start_held", aes_start, 1);
      chk("bp_key_stable", aes_key, k0);
    end
    cyc();
    aes_ready = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    chk("bp_start_cycles", ast_cnt, 6);
    chk("bp_transfers", xfer_cnt, 1);
    cyc();
    chk("bp_tried", tried_cnt, 1);

    // Abort in WAIT, engine result lands afterwards.
    prep(10, 10, 3, '1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    abort = 1'b1;
    @(negedge clk);
    chk("abort_kg_ena", kg_ena, 0);
    chk("abort_aes_start", aes_start, 0);
    cyc();
    abort = 1'b0;
    repeat (4) cyc();
    chk("abort_busy", busy, 0);
    chk("abort_found", found, 0);
    chk("abort_ena", ena_cnt[0] + ena_cnt[1], 0);
    chk("abort_tried", tried_cnt, 0);
    chk("abort_xfer", xfer_cnt, 1);

    // Reset in WAIT behaves the same way.
    prep(10, 10, 3, '1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (4) cyc();
    chk("rstw_busy", busy, 0);
    chk("rstw_found", found, 0);
    chk("rstw_ena", ena_cnt[0] + ena_cnt[1], 0);
    chk("rstw_aes_key", aes_key, 0);
    chk("rstw_tried", tried_cnt, 0);

    chk("kg_ena_onehot", bad_oh, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
